// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: front end for the ffSR stage.
// Synchronizes and debounces raw set/clear requests, turns rising edges into
// single-cycle s/r pulses with a hold-off gap, drops commands that would not
// change the downstream flop, and counts set/clear collisions.
//
// state | meaning
// IDLE  | waiting for a pending command
// ISSUE | one-cycle s or r pulse being driven
// HOLD  | forced idle gap after a pulse, counting HOLDOFF down to 0

module sr_cmd_gen #(
  parameter int DEBOUNCE = 4,
  parameter int HOLDOFF  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_in,
  input  logic             clr_in,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             state_q
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Channel index 1 is set, index 0 is clear, so a rise vector maps
  // directly onto the pending kind encoding (SET=1, CLR=0).
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    rise;
  logic [DW-1:0] deb_cnt [2];

  logic          pend_v;
  logic          pend_kind;
  logic          consume;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          issue_kind;

  assign raw  = {set_in, clr_in};
  assign rise = deb & ~deb_d;

  // IDLE always takes the pending entry: either issues it or drops it.
  assign consume = (state == IDLE) && pend_v;

  assign busy = (state != IDLE) || pend_v;

  // Two-flop synchronizer on both raw request lines.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: deb follows sync2 only after DEBOUNCE cycles of disagreement.
  always_ff @(posedge clock) begin
    if (!reset) begin
      deb        <= '0;
      deb_d      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Single-entry pending register with last-request-wins and conflict accounting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_v       <= 1'b0;
      pend_kind    <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= 1'b0;
      if (rise[1] && rise[0]) begin
        // Colliding requests are both thrown away; an older entry survives
        // unless the FSM is taking it this cycle.
        conflict <= 1'b1;
        if (conflict_cnt != {CNT_W{1'b1}}) begin
          conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
        if (consume) begin
          pend_v <= 1'b0;
        end
      end else if (rise[1] || rise[0]) begin
        // A new request replaces the entry even if the FSM consumes it now.
        pend_v    <= 1'b1;
        pend_kind <= rise[1];
      end else if (consume) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Command FSM with registered s/r pulses and the downstream y mirror.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      issue_kind <= 1'b0;
      s          <= 1'b0;
      r          <= 1'b0;
      state_q    <= 1'b0;
    end else begin
      s <= 1'b0;
      r <= 1'b0;
      case (state)
        IDLE: begin
          // A command matching the mirror is dropped by the pending logic.
          if (pend_v && (pend_kind != state_q)) begin
            state      <= ISSUE;
            issue_kind <= pend_kind;
            s          <= pend_kind;
            r          <= ~pend_kind;
          end
        end
        ISSUE: begin
          state_q <= issue_kind;
          if (HOLDOFF > 0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt <= HW'(1)) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen. Instance dut uses the defaults
// (DEBOUNCE=4, HOLDOFF=2, CNT_W=8); instance dut2 uses DEBOUNCE=1,
// HOLDOFF=2, CNT_W=2 so the conflict counter saturates and a second
// request can land inside HOLD.

module tb_sr_cmd_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       set_in = 1'b0;
  logic       clr_in = 1'b0;
  logic       set2 = 1'b0;
  logic       clr2 = 1'b0;

  logic       s, r, busy, conflict, state_q;
  logic [7:0] conflict_cnt;
  logic       s2, r2, busy2, conflict2, state_q2;
  logic [1:0] conflict_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor-owned event counters (written only by the monitor process).
  logic mon_en = 1'b0;
  int   s_cnt = 0, r_cnt = 0, conf_cnt = 0, busy_cyc = 0, both_cnt = 0;
  int   s2_cnt = 0, r2_cnt = 0;

  int s0, r0, c0, b0;

  sr_cmd_gen dut (
    .clock        (clock),
    .reset        (reset),
    .set_in       (set_in),
    .clr_in       (clr_in),
    .s            (s),
    .r            (r),
    .busy         (busy),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt),
    .state_q      (state_q)
  );

  sr_cmd_gen #(.DEBOUNCE(1), .HOLDOFF(2), .CNT_W(2)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .set_in       (set2),
    .clr_in       (clr2),
    .s            (s2),
    .r            (r2),
    .busy         (busy2),
    .conflict     (conflict2),
    .conflict_cnt (conflict_cnt2),
    .state_q      (state_q2)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (s) s_cnt++;
      if (r) r_cnt++;
      if (conflict) conf_cnt++;
      if (busy) busy_cyc++;
      if ((s && r) || (s2 && r2)) both_cnt++;
      if (s2) s2_cnt++;
      if (r2) r2_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held for three edges with raw inputs toggling.
    for (int i = 0; i < 3; i++) begin
      set_in = ~set_in;
      clr_in = ~clr_in;
      set2   = ~set2;
      clr2   = ~clr2;
      tick(1);
      check_val("rst_outs", {s, r, busy, conflict, state_q, conflict_cnt}, 32'h0);
      check_val("rst_outs2", {s2, r2, busy2, conflict2, state_q2, conflict_cnt2}, 32'h0);
    end

    // Release with set_in held: s appears 7 edges after first sampling.
    reset  = 1'b1;
    set_in = 1'b1;
    clr_in = 1'b0;
    set2   = 1'b0;
    clr2   = 1'b0;
    mon_en = 1'b1;
    tick(7);
    check_val("lat_pre_s", s, 1'b0);
    tick(1);
    check_val("lat_s", {s, r}, 2'b10);
    tick(1);
    check_val("lat_q", {s, state_q}, 2'b01);
    set_in = 1'b0;
    tick(20);
    check_val("lat_once", s_cnt, 1);

    // Glitches shorter than DEBOUNCE are ignored.
    r0 = r_cnt; s0 = s_cnt; b0 = busy_cyc;
    clr_in = 1'b1;
    tick(3);
    clr_in = 1'b0;
    tick(15);
    set_in = 1'b1;
    tick(3);
    set_in = 1'b0;
    tick(15);
    check_val("glitch_pulses", (r_cnt - r0) + (s_cnt - s0), 0);
    check_val("glitch_busy", busy_cyc - b0, 0);

    // Normal clear then set.
    r0 = r_cnt; s0 = s_cnt;
    clr_in = 1'b1;
    tick(8);
    check_val("norm_r", {s, r}, 2'b01);
    tick(1);
    check_val("norm_q0", {r, state_q}, 2'b00);
    clr_in = 1'b0;
    tick(20);
    set_in = 1'b1;
    tick(8);
    check_val("norm_s", {s, r}, 2'b10);
    tick(1);
    check_val("norm_q1", state_q, 1'b1);
    set_in = 1'b0;
    tick(20);
    check_val("norm_counts", {8'(s_cnt - s0), 8'(r_cnt - r0)}, 16'h0101);

    // Redundant sets while state_q is already 1.
    s0 = s_cnt; b0 = busy_cyc;
    for (int k = 0; k < 2; k++) begin
      set_in = 1'b1;
      tick(10);
      set_in = 1'b0;
      tick(12);
    end
    check_val("redund_no_s", s_cnt - s0, 0);
    check_val("redund_q", state_q, 1'b1);
    check_val("redund_seen", (busy_cyc - b0) > 0, 1'b1);

    // Five simultaneous set/clear rises on both instances.
    s0 = s_cnt; r0 = r_cnt; c0 = conf_cnt;
    for (int i = 0; i < 5; i++) begin
      set_in = 1'b1; clr_in = 1'b1; set2 = 1'b1; clr2 = 1'b1;
      tick(7);
      check_val("conf_pulse", conflict, 1'b1);
      if (i == 0) begin
        check_val("conf_cnt1", conflict_cnt, 8'd1);
        check_val("conf_cnt1_w2", conflict_cnt2, 2'd1);
      end
      tick(1);
      check_val("conf_end", conflict, 1'b0);
      set_in = 1'b0; clr_in = 1'b0; set2 = 1'b0; clr2 = 1'b0;
      tick(15);
    end
    check_val("conf_cnt5", conflict_cnt, 8'd5);
    check_val("conf_sat", conflict_cnt2, 2'd3);
    check_val("conf_pulses", conf_cnt - c0, 5);
    check_val("conf_no_cmd", (s_cnt - s0) + (r_cnt - r0) + s2_cnt + r2_cnt, 0);

    // dut2: s pulse, then a clear captured right after it and a set
    // captured during HOLD; the set wins and is dropped as redundant.
    set2 = 1'b1;
    tick(1);
    set2 = 1'b0;
    tick(1);
    clr2 = 1'b1;
    tick(1);
    set2 = 1'b1;
    tick(2);
    check_val("ho_s", {s2, r2}, 2'b10);
    tick(1);
    check_val("ho_q_busy", {state_q2, busy2}, 2'b11);
    tick(3);
    check_val("ho_drop_idle", busy2, 1'b0);
    tick(10);
    check_val("ho_no_r", r2_cnt, 0);
    check_val("ho_one_s", s2_cnt, 1);
    check_val("ho_q_final", state_q2, 1'b1);
    set2 = 1'b0;
    clr2 = 1'b0;
    tick(5);

    check_val("s_and_r", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
